elevator_req_sched: RTL and testbench
=====================================

# elevator_req_sched

Request-scheduling stage directly upstream of the 5-floor elevator controller. Latches hall/cab button presses into a pending-request register, picks the next target floor with a direction-preserving (SCAN) policy, and hands it to the controller over a valid/ready handshake. Clears each request when the car reports arrival at that floor.

## Interface
- `NUM_FLOORS`, 5: number of floors; floors numbered 0..NUM_FLOORS-1.
- `FLOOR_W`, 3: width of binary floor numbers; must satisfy 2^FLOOR_W >= NUM_FLOORS.

- `clk`  in  1  single clock; all logic on rising edge.
- `rst_n`  in  1  synchronous, active-low reset, sampled on rising edge of `clk`.
- `btn_req`  in  NUM_FLOORS  one level per floor button; a 0->1 transition is one press.
- `cur_floor`  in  FLOOR_W  binary current car position, from controller.
- `arrive`  in  1  one-cycle pulse: car stopped at `cur_floor`.
- `tgt_ready`  in  1  controller accepts a target.
- `tgt_valid`  out  1  target offered.
- `tgt_floor`  out  FLOOR_W  offered target floor, binary.
- `dir_up`  out  1  current sweep direction, 1 = up.
- `pending`  out  NUM_FLOORS  outstanding requests, bit i = floor i.

## Operation
- Reset (`rst_n`=0 at an edge): state IDLE, `pending`=0, `tgt_valid`=0, `tgt_floor`=0, `dir_up`=1, button-history register=0.
- Edge detect: registered `btn_prev`; press on floor i when `btn_req[i] & ~btn_prev[i]`. A button held through reset counts as one press on the first edge after reset. Held buttons do not re-trigger.
- Pending update per edge: `pending_next = (pending | press) & ~clr`. `clr` is one-hot of `cur_floor` when `arrive`=1 and state is WAIT_ARRIVE, else 0. Clear wins over a simultaneous press on the same floor.
- `arrive` with `cur_floor` >= NUM_FLOORS is ignored: no clear, no state change.
- FSM:
  - IDLE: `pending`!=0 -> SELECT; else stay.
  - SELECT: register `tgt_floor` from selection, set `tgt_valid`=1, update `dir_up` -> ISSUE. If `pending` is 0 -> IDLE.
  - ISSUE: hold `tgt_valid`=1 and `tgt_floor` stable. On `tgt_valid & tgt_ready`: drop `tgt_valid` -> WAIT_ARRIVE.
  - WAIT_ARRIVE: on valid `arrive` -> SELECT if `pending_next`!=0, else IDLE. `arrive` in any other state is ignored.
- Selection, using `pending` as registered at SELECT:
  - `dir_up`=1: lowest pending floor >= `cur_floor`. If none, set `dir_up`=0 and take the highest pending floor < `cur_floor`.
  - `dir_up`=0: highest pending floor <= `cur_floor`. If none, set `dir_up`=1 and take the lowest pending floor > `cur_floor`.
- A request at `cur_floor` is a valid target; the controller stops in place.
- No retargeting: presses during ISSUE/WAIT_ARRIVE only update `pending`.
- All comparisons are unsigned FLOOR_W-bit.

## Timing
- Press edge sampled at edge E0 -> `pending` bit visible after E0.
- IDLE->SELECT at E1; `tgt_valid`=1 with `tgt_floor` after E2. Idle press-to-offer latency is 3 edges.
- Handshake completes on the edge where both `tgt_valid` and `tgt_ready` are 1. `tgt_valid` is low the following cycle.
- `tgt_ready` high before `tgt_valid` is permitted; acceptance occurs on the first edge where both are high.
- Arrive at edge A: bit cleared after A. If requests remain, new `tgt_valid` after A+1.
- `rst_n` low mid-operation: all outputs return to reset values after that edge, regardless of state or a handshake in progress.

## Test plan
- Reset, `cur_floor`=0, rise `btn_req[3]` -> `pending`=5'b01000 after E0; `tgt_valid`=1, `tgt_floor`=3, `dir_up`=1 after E2. `tgt_ready`=1 -> `tgt_valid`=0 next cycle. `arrive` with `cur_floor`=3 -> `pending`=0, state IDLE.
- `cur_floor`=2, `dir_up`=1, pending floors {0,4} -> target 4. Arrive at 4 -> target 0 with `dir_up`=0.
- `cur_floor`=3, `dir_up`=1, pending {1} -> `dir_up` flips to 0, target 1.
- `tgt_ready` held low 10 cycles while `btn_req[0]` presses -> `tgt_floor` unchanged and `tgt_valid` high throughout; `pending[0]` set.
- Press floor 2 on the same edge as `arrive` at `cur_floor`=2 -> `pending[2]`=0. `btn_req[2]` held high 5 cycles -> no further sets.
- `rst_n`=0 during ISSUE with `pending`=5'b10110 -> after that edge `pending`=0, `tgt_valid`=0, `dir_up`=1, `tgt_floor`=0.

Source files
------------

// File: rtl/elevator_req_sched.sv
// Request scheduler for the elevator controller: latches button presses into
// a pending-request register, picks the next target with a SCAN policy and
// offers it to the controller over a valid/ready handshake.
module elevator_req_sched #(
    parameter int NUM_FLOORS = 5,
    parameter int FLOOR_W    = 3
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [NUM_FLOORS-1:0] btn_req,
    input  logic [FLOOR_W-1:0]    cur_floor,
    input  logic                  arrive,
    input  logic                  tgt_ready,
    output logic                  tgt_valid,
    output logic [FLOOR_W-1:0]    tgt_floor,
    output logic                  dir_up,
    output logic [NUM_FLOORS-1:0] pending
);

    typedef enum logic [1:0] {
        IDLE,
        SELECT,
        ISSUE,
        WAIT_ARRIVE
    } state_t;

    localparam logic [FLOOR_W:0] FLOOR_LIMIT = (FLOOR_W+1)'(NUM_FLOORS);

    state_t                  state;
    logic [NUM_FLOORS-1:0]   btn_prev;
    logic [NUM_FLOORS-1:0]   press;
    logic [NUM_FLOORS-1:0]   clr;
    logic [NUM_FLOORS-1:0]   pending_next;
    logic                    arrive_ok;

    logic                    up_ge_hit;
    logic                    up_gt_hit;
    logic                    dn_le_hit;
    logic                    dn_lt_hit;
    logic [FLOOR_W-1:0]      up_ge;
    logic [FLOOR_W-1:0]      up_gt;
    logic [FLOOR_W-1:0]      dn_le;
    logic [FLOOR_W-1:0]      dn_lt;
    logic [FLOOR_W-1:0]      sel_floor;
    logic                    sel_dir_up;

    // Press detection, arrival qualification and next pending set (clear wins)
    always_comb begin
        press     = btn_req & ~btn_prev;
        arrive_ok = (state == WAIT_ARRIVE) && arrive
                    && ({1'b0, cur_floor} < FLOOR_LIMIT);
        clr       = '0;
        for (int unsigned i = 0; i < NUM_FLOORS; i++) begin
            if (arrive_ok && (cur_floor == FLOOR_W'(i))) begin
                clr[i] = 1'b1;
            end
        end
        pending_next = (pending | press) & ~clr;
    end

    // Nearest pending floor on each side of the car, then the SCAN choice
    always_comb begin
        up_ge_hit  = 1'b0;
        up_gt_hit  = 1'b0;
        dn_le_hit  = 1'b0;
        dn_lt_hit  = 1'b0;
        up_ge      = '0;
        up_gt      = '0;
        dn_le      = '0;
        dn_lt      = '0;
        // ascending scan: first hit above is the lowest, last hit below is the highest
        for (int unsigned i = 0; i < NUM_FLOORS; i++) begin
            if (pending[i]) begin
                if ((FLOOR_W'(i) >= cur_floor) && !up_ge_hit) begin
                    up_ge_hit = 1'b1;
                    up_ge     = FLOOR_W'(i);
                end
                if ((FLOOR_W'(i) > cur_floor) && !up_gt_hit) begin
                    up_gt_hit = 1'b1;
                    up_gt     = FLOOR_W'(i);
                end
                if (FLOOR_W'(i) <= cur_floor) begin
                    dn_le_hit = 1'b1;
                    dn_le     = FLOOR_W'(i);
                end
                if (FLOOR_W'(i) < cur_floor) begin
                    dn_lt_hit = 1'b1;
                    dn_lt     = FLOOR_W'(i);
                end
            end
        end

        sel_floor  = tgt_floor;
        sel_dir_up = dir_up;
        if (dir_up) begin
            if (up_ge_hit) begin
                sel_floor  = up_ge;
                sel_dir_up = 1'b1;
            end else if (dn_lt_hit) begin
                sel_floor  = dn_lt;
                sel_dir_up = 1'b0;
            end
        end else begin
            if (dn_le_hit) begin
                sel_floor  = dn_le;
                sel_dir_up = 1'b0;
            end else if (up_gt_hit) begin
                sel_floor  = up_gt;
                sel_dir_up = 1'b1;
            end
        end
    end

    // Scheduler FSM with registered outputs and request bookkeeping
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state     <= IDLE;
            btn_prev  <= '0;
            pending   <= '0;
            tgt_valid <= 1'b0;
            tgt_floor <= '0;
            dir_up    <= 1'b1;
        end else begin
            btn_prev <= btn_req;
            pending  <= pending_next;
            case (state)
                IDLE: begin
                    if (pending != '0) begin
                        state <= SELECT;
                    end
                end
                SELECT: begin
                    if (pending == '0) begin
                        state <= IDLE;
                    end else begin
                        tgt_floor <= sel_floor;
                        dir_up    <= sel_dir_up;
                        tgt_valid <= 1'b1;
                        state     <= ISSUE;
                    end
                end
                ISSUE: begin
                    if (tgt_valid && tgt_ready) begin
                        tgt_valid <= 1'b0;
                        state     <= WAIT_ARRIVE;
                    end
                end
                WAIT_ARRIVE: begin
                    if (arrive_ok) begin
                        state <= (pending_next != '0) ? SELECT : IDLE;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_elevator_req_sched.sv
// Bench for elevator_req_sched: directed scenarios plus a randomized run
// checked against a behavioural model of the scheduling rules.
module tb_elevator_req_sched;

    logic       clk;
    logic       rst_n;
    logic [4:0] btn_req;
    logic [2:0] cur_floor;
    logic       arrive;
    logic       tgt_ready;
    logic       tgt_valid;
    logic [2:0] tgt_floor;
    logic       dir_up;
    logic [4:0] pending;

    int n_tests = 0;
    int n_fail  = 0;

    // behavioural model: request set, offer, sweep direction and a phase
    // (0 idle, 1 choosing, 2 offering, 3 travelling)
    bit [4:0] m_pend;
    bit [4:0] m_prev;
    bit       m_valid;
    bit [2:0] m_tgt;
    bit       m_dir;
    int       m_phase;

    elevator_req_sched #(.NUM_FLOORS(5), .FLOOR_W(3)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .btn_req   (btn_req),
        .cur_floor (cur_floor),
        .arrive    (arrive),
        .tgt_ready (tgt_ready),
        .tgt_valid (tgt_valid),
        .tgt_floor (tgt_floor),
        .dir_up    (dir_up),
        .pending   (pending)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // SCAN choice: nearest request ahead in the sweep, else reverse
    function automatic void pick(input bit [4:0] p, input int cur, input bit d,
                                 output int t, output bit nd);
        int lo_ahead = 99;
        int hi_behind = -1;
        if (d) begin
            for (int f = 0; f < 5; f++)
                if (p[f] && f >= cur && f < lo_ahead) lo_ahead = f;
            for (int f = 0; f < 5; f++)
                if (p[f] && f < cur && f > hi_behind) hi_behind = f;
            if (lo_ahead != 99) begin t = lo_ahead; nd = 1'b1; end
            else begin t = hi_behind; nd = 1'b0; end
        end else begin
            for (int f = 0; f < 5; f++)
                if (p[f] && f <= cur && f > hi_behind) hi_behind = f;
            for (int f = 0; f < 5; f++)
                if (p[f] && f > cur && f < lo_ahead) lo_ahead = f;
            if (hi_behind != -1) begin t = hi_behind; nd = 1'b0; end
            else begin t = lo_ahead; nd = 1'b1; end
        end
    endfunction

    // advance model with the inputs seen at this edge, then clock the DUT
    task automatic step();
        bit [4:0] prs;
        bit [4:0] clr;
        bit [4:0] pn;
        bit       arr_ok;
        int       c;
        int       t;
        bit       nd;
        c = int'(cur_floor);
        if (!rst_n) begin
            m_pend = '0; m_prev = '0; m_valid = 1'b0;
            m_tgt = '0; m_dir = 1'b1; m_phase = 0;
        end else begin
            prs    = btn_req & ~m_prev;
            arr_ok = arrive && (c < 5) && (m_phase == 3);
            clr    = arr_ok ? 5'(1 << c) : 5'b0;
            pn     = (m_pend | prs) & ~clr;
            case (m_phase)
                0: if (m_pend != 0) m_phase = 1;
                1: begin
                    if (m_pend == 0) m_phase = 0;
                    else begin
                        pick(m_pend, c, m_dir, t, nd);
                        m_tgt = 3'(t); m_dir = nd; m_valid = 1'b1; m_phase = 2;
                    end
                end
                2: if (tgt_ready) begin m_valid = 1'b0; m_phase = 3; end
                default: if (arr_ok) m_phase = (pn != 0) ? 1 : 0;
            endcase
            m_pend = pn;
            m_prev = btn_req;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; btn_req = '0; cur_floor = '0; arrive = 1'b0; tgt_ready = 1'b0;
        step(); step();
        n_tests++; if (pending !== 5'b0) begin n_fail++; $display("FAIL reset_pending got %b exp 00000", pending); end
        n_tests++; if (tgt_valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid got %b exp 0", tgt_valid); end
        n_tests++; if (tgt_floor !== 3'd0) begin n_fail++; $display("FAIL reset_tgt got %0d exp 0", tgt_floor); end
        n_tests++; if (dir_up !== 1'b1) begin n_fail++; $display("FAIL reset_dir got %b exp 1", dir_up); end
        rst_n = 1'b1;
        step();
        n_tests++; if (tgt_valid !== 1'b0) begin n_fail++; $display("FAIL reset_idle_valid got %b exp 0", tgt_valid); end
    endtask

    task automatic test_basic();
        cur_floor = 3'd0; btn_req = 5'b01000;
        step();
        n_tests++; if (pending !== 5'b01000) begin n_fail++; $display("FAIL basic_e0_pending got %b exp 01000", pending); end
        n_tests++; if (tgt_valid !== 1'b0) begin n_fail++; $display("FAIL basic_e0_valid got %b exp 0", tgt_valid); end
        step();
        n_tests++; if (tgt_valid !== 1'b0) begin n_fail++; $display("FAIL basic_e1_valid got %b exp 0", tgt_valid); end
        step();
        n_tests++; if (tgt_valid !== 1'b1) begin n_fail++; $display("FAIL basic_e2_valid got %b exp 1", tgt_valid); end
        n_tests++; if (tgt_floor !== 3'd3) begin n_fail++; $display("FAIL basic_e2_tgt got %0d exp 3", tgt_floor); end
        n_tests++; if (dir_up !== 1'b1) begin n_fail++; $display("FAIL basic_e2_dir got %b exp 1", dir_up); end
        tgt_ready = 1'b1; step(); tgt_ready = 1'b0;
        n_tests++; if (tgt_valid !== 1'b0) begin n_fail++; $display("FAIL basic_accept_valid got %b exp 0", tgt_valid); end
        btn_req = '0; cur_floor = 3'd3; arrive = 1'b1; step(); arrive = 1'b0;
        n_tests++; if (pending !== 5'b0) begin n_fail++; $display("FAIL basic_arrive_pending got %b exp 00000", pending); end
        step(); step();
        n_tests++; if (tgt_valid !== 1'b0) begin n_fail++; $display("FAIL basic_idle_valid got %b exp 0", tgt_valid); end
    endtask

    task automatic test_scan();
        cur_floor = 3'd2; btn_req = 5'b10001;
        step();
        n_tests++; if (pending !== 5'b10001) begin n_fail++; $display("FAIL scan_pending got %b exp 10001", pending); end
        step(); step();
        n_tests++; if (tgt_floor !== 3'd4 || tgt_valid !== 1'b1 || dir_up !== 1'b1) begin
            n_fail++; $display("FAIL scan_first got tgt=%0d v=%b dir=%b exp tgt=4 v=1 dir=1", tgt_floor, tgt_valid, dir_up); end
        tgt_ready = 1'b1; step(); tgt_ready = 1'b0;
        cur_floor = 3'd4; arrive = 1'b1; step(); arrive = 1'b0;
        n_tests++; if (pending !== 5'b00001) begin n_fail++; $display("FAIL scan_after_arrive got %b exp 00001", pending); end
        step();
        n_tests++; if (tgt_floor !== 3'd0 || tgt_valid !== 1'b1 || dir_up !== 1'b0) begin
            n_fail++; $display("FAIL scan_reverse got tgt=%0d v=%b dir=%b exp tgt=0 v=1 dir=0", tgt_floor, tgt_valid, dir_up); end
        tgt_ready = 1'b1; step(); tgt_ready = 1'b0;
        cur_floor = 3'd0; arrive = 1'b1; step(); arrive = 1'b0; btn_req = '0;
        n_tests++; if (pending !== 5'b0) begin n_fail++; $display("FAIL scan_drain got %b exp 00000", pending); end
        step();
    endtask

    task automatic test_flip_and_hold();
        rst_n = 1'b0; step(); rst_n = 1'b1;
        cur_floor = 3'd3; btn_req = 5'b00010;
        step(); step(); step();
        n_tests++; if (tgt_floor !== 3'd1 || dir_up !== 1'b0) begin
            n_fail++; $display("FAIL flip got tgt=%0d dir=%b exp tgt=1 dir=0", tgt_floor, dir_up); end
        btn_req = 5'b00011;
        for (int i = 0; i < 10; i++) begin
            step();
            n_tests++; if (tgt_valid !== 1'b1 || tgt_floor !== 3'd1) begin
                n_fail++; $display("FAIL hold_stable cyc %0d got v=%b tgt=%0d exp v=1 tgt=1", i, tgt_valid, tgt_floor); end
        end
        n_tests++; if (pending !== 5'b00011) begin n_fail++; $display("FAIL hold_pending got %b exp 00011", pending); end
        tgt_ready = 1'b1; step(); tgt_ready = 1'b0;
        cur_floor = 3'd1; arrive = 1'b1; step(); arrive = 1'b0;
        n_tests++; if (pending !== 5'b00001) begin n_fail++; $display("FAIL hold_arrive got %b exp 00001", pending); end
        step();
        n_tests++; if (tgt_valid !== 1'b1 || tgt_floor !== 3'd0 || dir_up !== 1'b0) begin
            n_fail++; $display("FAIL hold_next got v=%b tgt=%0d dir=%b exp v=1 tgt=0 dir=0", tgt_valid, tgt_floor, dir_up); end
        tgt_ready = 1'b1; step(); tgt_ready = 1'b0;
        cur_floor = 3'd0; arrive = 1'b1; step(); arrive = 1'b0; btn_req = '0;
        step();
    endtask

    task automatic test_clear_wins();
        btn_req = 5'b10000;
        step(); step(); step();
        n_tests++; if (tgt_floor !== 3'd4 || dir_up !== 1'b1) begin
            n_fail++; $display("FAIL clr_setup got tgt=%0d dir=%b exp tgt=4 dir=1", tgt_floor, dir_up); end
        tgt_ready = 1'b1; step(); tgt_ready = 1'b0;
        cur_floor = 3'd2; arrive = 1'b1; btn_req = 5'b10100; step(); arrive = 1'b0;
        n_tests++; if (pending !== 5'b10000) begin n_fail++; $display("FAIL clr_wins got %b exp 10000", pending); end
        for (int i = 0; i < 5; i++) begin
            step();
            n_tests++; if (pending[2] !== 1'b0) begin n_fail++; $display("FAIL clr_held cyc %0d got %b exp 0", i, pending[2]); end
        end
        n_tests++; if (tgt_valid !== 1'b1 || tgt_floor !== 3'd4) begin
            n_fail++; $display("FAIL clr_reoffer got v=%b tgt=%0d exp v=1 tgt=4", tgt_valid, tgt_floor); end
        tgt_ready = 1'b1; step(); tgt_ready = 1'b0;
        cur_floor = 3'd4; arrive = 1'b1; btn_req = '0; step(); arrive = 1'b0;
        n_tests++; if (pending !== 5'b0) begin n_fail++; $display("FAIL clr_drain got %b exp 00000", pending); end
        step();
    endtask

    task automatic test_ignore_arrive();
        cur_floor = 3'd0; btn_req = 5'b00100;
        step(); step(); step();
        tgt_ready = 1'b1; step(); tgt_ready = 1'b0;
        cur_floor = 3'd6; arrive = 1'b1; step(); arrive = 1'b0;
        n_tests++; if (pending !== 5'b00100) begin n_fail++; $display("FAIL ign_pending6 got %b exp 00100", pending); end
        step();
        n_tests++; if (tgt_valid !== 1'b0) begin n_fail++; $display("FAIL ign_valid got %b exp 0", tgt_valid); end
        cur_floor = 3'd5; arrive = 1'b1; step(); arrive = 1'b0;
        n_tests++; if (pending !== 5'b00100) begin n_fail++; $display("FAIL ign_pending5 got %b exp 00100", pending); end
        cur_floor = 3'd2; arrive = 1'b1; step(); arrive = 1'b0;
        n_tests++; if (pending !== 5'b0) begin n_fail++; $display("FAIL ign_real_arrive got %b exp 00000", pending); end
        btn_req = '0; step();
    endtask

    task automatic test_reset_mid();
        cur_floor = 3'd0; btn_req = 5'b10110;
        step();
        n_tests++; if (pending !== 5'b10110) begin n_fail++; $display("FAIL rmid_pending got %b exp 10110", pending); end
        step(); step();
        n_tests++; if (tgt_valid !== 1'b1) begin n_fail++; $display("FAIL rmid_issue got %b exp 1", tgt_valid); end
        rst_n = 1'b0; btn_req = 5'b00010; step();
        n_tests++; if (pending !== 5'b0 || tgt_valid !== 1'b0 || dir_up !== 1'b1 || tgt_floor !== 3'd0) begin
            n_fail++; $display("FAIL rmid_reset got p=%b v=%b dir=%b tgt=%0d exp p=00000 v=0 dir=1 tgt=0",
                               pending, tgt_valid, dir_up, tgt_floor); end
        rst_n = 1'b1; step();
        n_tests++; if (pending !== 5'b00010) begin n_fail++; $display("FAIL rmid_held_press got %b exp 00010", pending); end
        btn_req = '0;
        rst_n = 1'b0; step(); rst_n = 1'b1; step();
    endtask

    task automatic test_random();
        for (int i = 0; i < 800; i++) begin
            btn_req   = btn_req ^ 5'($urandom & $urandom & $urandom);
            cur_floor = ($urandom_range(0, 7) == 0) ? 3'($urandom_range(5, 7)) : 3'($urandom_range(0, 4));
            arrive    = ($urandom_range(0, 3) == 0);
            tgt_ready = ($urandom_range(0, 2) != 0);
            rst_n     = ($urandom_range(0, 149) != 0);
            step();
            n_tests++; if (pending !== m_pend) begin n_fail++; $display("FAIL rnd_pending cyc %0d got %b exp %b", i, pending, m_pend); end
            n_tests++; if (tgt_valid !== m_valid) begin n_fail++; $display("FAIL rnd_valid cyc %0d got %b exp %b", i, tgt_valid, m_valid); end
            n_tests++; if (tgt_floor !== m_tgt) begin n_fail++; $display("FAIL rnd_tgt cyc %0d got %0d exp %0d", i, tgt_floor, m_tgt); end
            n_tests++; if (dir_up !== m_dir) begin n_fail++; $display("FAIL rnd_dir cyc %0d got %b exp %b", i, dir_up, m_dir); end
        end
        rst_n = 1'b1; arrive = 1'b0; tgt_ready = 1'b0;
    endtask

    initial begin
        test_reset();
        test_basic();
        test_scan();
        test_flip_and_hold();
        test_clear_wins();
        test_ignore_arrive();
        test_reset_mid();
        test_random();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
